// File: rtl/midi_pkg.sv
// Shared MIDI definitions for the transmit and receive paths.
package midi_pkg;

  // Serializer states for one 8N1 frame.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Default sample clocks per serial bit, shared with uart_rx.
  localparam int unsigned MIDI_BAUD_CLKS = 8;

  // MSB set marks a MIDI status byte.
  localparam logic [7:0] STATUS_MASK = 8'h80;

  // True for status bytes (including realtime messages).
  function automatic logic is_status(input logic [7:0] b);
    return (b & STATUS_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a first-word
// fall-through read port (rd_data always shows the head entry).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  // A write while full is ignored even if a read frees space on the same edge.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];
  assign level   = count;

  // Occupancy after this edge's accepted write/read.
  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and flags; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/midi_tx_buf.sv
// Buffered MIDI/UART transmitter: queues router bytes in a FIFO and sends
// each one as an 8N1 frame on tx, back-to-back while bytes are waiting.
module midi_tx_buf
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = MIDI_BAUD_CLKS,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy
);

  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [CW-1:0] clk_cnt;
  logic [CW-1:0] clk_cnt_nxt;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_nxt;
  logic [7:0]    sr;
  logic [7:0]    sr_nxt;
  logic          tx_nxt;
  logic          pop;
  logic          empty;
  logic [7:0]    head;
  logic          bit_end;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign bit_end = (clk_cnt == CNT_LAST);
  assign busy    = (state != IDLE) || (level != '0);

  // Serializer state, counters, shift register and the registered line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      sr      <= sr_nxt;
      tx      <= tx_nxt;
    end
  end

  // Frame sequencing: pop, start bit, 8 data bits LSB first, stop bit.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    sr_nxt      = sr;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        tx_nxt      = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          sr_nxt    = head;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          tx_nxt      = sr[0];
          sr_nxt      = sr >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_cnt == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            tx_nxt      = sr[0];
            sr_nxt      = sr >> 1;
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          // A queued byte chains straight into its start bit with no idle gap.
          if (!empty) begin
            pop       = 1'b1;
            sr_nxt    = head;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        tx_nxt      = 1'b1;
      end
    endcase
  end

  // Dropped-write indication, one cycle wide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= wr_en && full;
  end

endmodule
